qtr_emu: RTL and testbench



---
 rtl/qtr_pkg.sv | 26 ++
 rtl/qtr_emu_if.sv | 33 +++
 rtl/qtr_tick_gen.sv | 44 ++++
 rtl/qtr_emu.sv | 177 +++++++++++++++++
 tb/tb_qtr_emu.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/qtr_pkg.sv
// qtr_pkg: definitions shared by the QTR emulator and the QTR timing reader.
//   - qtr_state_e : emulator state encoding (3-bit)
//   - ten_us_count: clock cycles per 10us tick for a given clock frequency.
//     The reader and the emulator both derive their tick length from it, so
//     their idea of "one 10us unit" always agrees.
package qtr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHARGE    = 3'd1,
    ST_HOLD_HIGH = 3'd2,
    ST_DRIVE_LOW = 3'd3,
    ST_WAIT_LOW  = 3'd4
  } qtr_state_e;

  localparam int unsigned QTR_CLK_FREQUENCY_DEF = 60_000_000;
  // Charge/tick counters; the tick length must stay below 1024 cycles.
  localparam int unsigned QTR_CNT_W = 10;
  // Reflectance value width, in 10us units.
  localparam int unsigned QTR_VAL_W = 8;

  function automatic int unsigned ten_us_count(input int unsigned clk_frequency);
    return clk_frequency / 100_000;
  endfunction

endpackage

// File: rtl/qtr_emu_if.sv
// qtr_emu_if: host-side and pad-side signals of one emulated QTR channel.
//   value_in     reflectance value to emulate, in 10us units
//   qtr_pin_in   raw line level from the I/O buffer (asynchronous)
//   qtr_ctrl_in  host LED control, 1 = LED on
//   qtr_out_en   pad output enable, 0 = tri-state
//   qtr_out_sig  pad output level when enabled
//   busy         emulator is not idle
//   done         one-cycle pulse when a discharge completes
//   err_short    one-cycle pulse when a charge pulse was too short
// master: the environment driving the emulator; slave: the emulator itself.
interface qtr_emu_if;
  import qtr_pkg::*;

  logic [QTR_VAL_W-1:0] value_in;
  logic                 qtr_pin_in;
  logic                 qtr_ctrl_in;
  logic                 qtr_out_en;
  logic                 qtr_out_sig;
  logic                 busy;
  logic                 done;
  logic                 err_short;

  modport master (
    output value_in, qtr_pin_in, qtr_ctrl_in,
    input  qtr_out_en, qtr_out_sig, busy, done, err_short
  );

  modport slave (
    input  value_in, qtr_pin_in, qtr_ctrl_in,
    output qtr_out_en, qtr_out_sig, busy, done, err_short
  );

endinterface

// File: rtl/qtr_tick_gen.sv
// qtr_tick_gen: free-running 10us tick counter with synchronous clear.
//   clk, rst  system clock, asynchronous active-high reset
//   clr_i     restart the period from zero (wins over en_i)
//   en_i      advance the counter this cycle
//   tick_o    high on the last cycle of each TICK_COUNT-cycle period
// With clr_i on cycle N and en_i held from N+1, tick_o fires on cycles
// N+TICK_COUNT, N+2*TICK_COUNT, ...
module qtr_tick_gen
  import qtr_pkg::*;
#(
  parameter int unsigned TICK_COUNT = ten_us_count(QTR_CLK_FREQUENCY_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [QTR_CNT_W-1:0] LAST = QTR_CNT_W'(TICK_COUNT - 1);

  logic [QTR_CNT_W-1:0] cnt_q;
  logic [QTR_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + QTR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/qtr_emu.sv
// qtr_emu: responder end of the QTR charge/discharge protocol.
// Watches the line; after a valid charge pulse it holds the line high for
// value x 10us, drives it low briefly and releases it.
//   clk    system clock
//   reset  asynchronous active-high reset; tri-states the pad at once
//   bus    qtr_emu_if.slave (value/LED inputs, raw pin, pad drive, status)
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | pad tri-stated, waiting for the host to charge the line
// ST_CHARGE    | counting synchronized-high cycles of the charge pulse
// ST_HOLD_HIGH | driving high, one value unit consumed per 10us tick
// ST_DRIVE_LOW | driving low for LOW_HOLD_CYCLES to discharge the line
// ST_WAIT_LOW  | tri-stated, waiting for the line to read low again
module qtr_emu
  import qtr_pkg::*;
#(
  parameter int unsigned          CLK_FREQUENCY   = QTR_CLK_FREQUENCY_DEF,
  parameter int unsigned          TEN_US_COUNT    = ten_us_count(CLK_FREQUENCY),
  parameter int unsigned          CHARGE_CYCLES   = TEN_US_COUNT,
  parameter int unsigned          LOW_HOLD_CYCLES = 4,
  parameter logic [QTR_VAL_W-1:0] DARK_VALUE      = 8'd255
) (
  input  logic     clk,
  input  logic     reset,
  qtr_emu_if.slave bus
);

  // The IDLE cycle that first sees the line high already counts as one
  // high sample, so CHARGE needs CHARGE_CYCLES-1 more; the counter starts
  // at 0 on the first CHARGE cycle and the last sample arrives at
  // CHARGE_CYCLES-2.
  localparam logic [QTR_CNT_W-1:0] CHARGE_LAST = QTR_CNT_W'(CHARGE_CYCLES - 2);
  localparam logic [QTR_CNT_W-1:0] LOW_LAST    = QTR_CNT_W'(LOW_HOLD_CYCLES - 1);

  logic                 sync1_q;
  logic                 pin_s_q;
  qtr_state_e           state_q;
  qtr_state_e           state_d;
  logic [QTR_CNT_W-1:0] cnt_q;
  logic [QTR_CNT_W-1:0] cnt_d;
  logic [QTR_VAL_W-1:0] v_q;
  logic [QTR_VAL_W-1:0] v_d;
  logic                 out_en_q;
  logic                 out_en_d;
  logic                 sig_q;
  logic                 sig_d;
  logic                 done_q;
  logic                 done_d;
  logic                 err_q;
  logic                 err_d;
  logic [QTR_VAL_W-1:0] snap_v;
  logic                 tick_clr;
  logic                 tick_en;
  logic                 tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      pin_s_q <= 1'b0;
    end else begin
      sync1_q <= bus.qtr_pin_in;
      pin_s_q <= sync1_q;
    end
  end

  qtr_tick_gen #(
    .TICK_COUNT (TEN_US_COUNT)
  ) u_tick (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    v_d      = v_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tick_clr = 1'b0;
    tick_en  = 1'b0;
    snap_v   = bus.qtr_ctrl_in ? bus.value_in : DARK_VALUE;

    case (state_q)
      ST_IDLE: begin
        if (pin_s_q) begin
          cnt_d   = '0;
          state_d = ST_CHARGE;
        end
      end

      ST_CHARGE: begin
        if (!pin_s_q) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CHARGE_LAST) begin
          // Snapshot: later value/LED changes must not touch this reading.
          v_d      = snap_v;
          cnt_d    = '0;
          tick_clr = 1'b1;
          state_d  = (snap_v == '0) ? ST_DRIVE_LOW : ST_HOLD_HIGH;
        end else begin
          cnt_d = cnt_q + QTR_CNT_W'(1);
        end
      end

      ST_HOLD_HIGH: begin
        tick_en = 1'b1;
        if (tick) begin
          v_d = v_q - QTR_VAL_W'(1);
          if (v_q == QTR_VAL_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_DRIVE_LOW;
          end
        end
      end

      ST_DRIVE_LOW: begin
        if (cnt_q == LOW_LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_LOW;
        end else begin
          cnt_d = cnt_q + QTR_CNT_W'(1);
        end
      end

      ST_WAIT_LOW: begin
        // Our own released high level must not look like a new charge.
        if (!pin_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        v_d     = '0;
      end
    endcase

    // Pad drive is registered from the next state so it lines up exactly
    // with the state it belongs to.
    out_en_d = (state_d == ST_HOLD_HIGH) || (state_d == ST_DRIVE_LOW);
    sig_d    = (state_d == ST_HOLD_HIGH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      v_q      <= '0;
      out_en_q <= 1'b0;
      sig_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      out_en_q <= out_en_d;
      sig_q    <= sig_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.qtr_out_en  = out_en_q;
  assign bus.qtr_out_sig = sig_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.err_short   = err_q;

endmodule

// File: tb/tb_qtr_emu.sv
module tb_qtr_emu;

  localparam int CLK_HZ = 2_000_000;
  localparam int T      = CLK_HZ / 100_000;
  localparam int LOWH   = 4;
  localparam int DARK   = 255;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  int   host_mode = 2;     // 0 = released, 1 = host drives high, 2 = host drives low
  logic cap_q     = 1'b0;  // line capacitance: holds the last driven level
  logic pad;
  int   checks    = 0;
  int   errors    = 0;

  qtr_emu_if bus ();

  qtr_emu #(
    .CLK_FREQUENCY   (CLK_HZ),
    .LOW_HOLD_CYCLES (LOWH),
    .DARK_VALUE      (8'd255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign pad = (host_mode == 1) ? 1'b1 :
               (host_mode == 2) ? 1'b0 :
               (bus.qtr_out_en ? bus.qtr_out_sig : cap_q);
  assign bus.qtr_pin_in = pad;

  always @(posedge clk) cap_q <= pad;

  // One charge/discharge exchange. The host charges the line for host_len
  // cycles, then releases it (or pulls it low). Returns how many cycles the
  // emulator drove high / low, done and err pulses, and the reader's
  // count of high cycles after release.
  task automatic serve(input logic [7:0] val, input logic ctrl, input int host_len,
                       input int after_mode, input bit scramble,
                       output int hi, output int lo, output int dn, output int er,
                       output int rd, output bit to);
    int bound;
    bit rd_stop;
    bound = host_len + (ctrl ? int'(val) : DARK) * T + 60;
    hi = 0; lo = 0; dn = 0; er = 0; rd = 0; to = 1'b1; rd_stop = 1'b0;
    bus.value_in    = val;
    bus.qtr_ctrl_in = ctrl;
    @(negedge clk);
    host_mode = 1;
    for (int n = 1; n < bound; n++) begin
      @(negedge clk);
      if (n == host_len) host_mode = after_mode;
      if (bus.qtr_out_en && bus.qtr_out_sig) hi++;
      if (bus.qtr_out_en && !bus.qtr_out_sig) lo++;
      if (bus.done) dn++;
      if (bus.err_short) er++;
      if (n >= host_len && !rd_stop) begin
        if (pad) rd++;
        else rd_stop = 1'b1;
      end
      if (scramble && bus.qtr_out_en) begin
        bus.value_in    = 8'($urandom);
        bus.qtr_ctrl_in = 1'($urandom_range(0, 1));
      end
      if (n > host_len && !bus.busy) begin
        to = 1'b0;
        break;
      end
    end
    host_mode = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; host_mode = 2; bus.value_in = '0; bus.qtr_ctrl_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.qtr_out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %b want 0", bus.qtr_out_en); end
    checks++; if (bus.qtr_out_sig !== 1'b0) begin errors++; $display("FAIL reset_out_sig got %b want 0", bus.qtr_out_sig); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.err_short !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_short); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    host_mode = 0;
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", bus.busy); end
  endtask

  task automatic test_fixed_values();
    logic [7:0] vals [4] = '{8'd5, 8'd0, 8'd7, 8'd1};
    logic       ctrls[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int hi, lo, dn, er, rd, exp_v;
    bit to;
    for (int i = 0; i < 4; i++) begin
      exp_v = ctrls[i] ? int'(vals[i]) : DARK;
      serve(vals[i], ctrls[i], T, 0, 1'b0, hi, lo, dn, er, rd, to);
      checks++; if (to) begin errors++; $display("FAIL fixed%0d timeout busy got %b want 0", i, bus.busy); end
      checks++; if (hi !== exp_v * T) begin errors++; $display("FAIL fixed%0d high_cycles got %0d want %0d", i, hi, exp_v * T); end
      checks++; if (lo !== LOWH) begin errors++; $display("FAIL fixed%0d low_cycles got %0d want %0d", i, lo, LOWH); end
      checks++; if (dn !== 1) begin errors++; $display("FAIL fixed%0d done_pulses got %0d want 1", i, dn); end
      checks++; if (er !== 0) begin errors++; $display("FAIL fixed%0d err_pulses got %0d want 0", i, er); end
      checks++; if (rd / T !== exp_v) begin errors++; $display("FAIL fixed%0d reader got %0d want %0d", i, rd / T, exp_v); end
    end
  endtask

  task automatic test_short_pulse();
    int lens[2] = '{5, T - 1};
    int hi, lo, dn, er, rd;
    bit to;
    for (int i = 0; i < 2; i++) begin
      serve(8'd6, 1'b1, lens[i], 2, 1'b0, hi, lo, dn, er, rd, to);
      checks++; if (to) begin errors++; $display("FAIL short%0d timeout busy got %b want 0", i, bus.busy); end
      checks++; if (er !== 1) begin errors++; $display("FAIL short%0d err_pulses got %0d want 1", i, er); end
      checks++; if (hi + lo !== 0) begin errors++; $display("FAIL short%0d drive_cycles got %0d want 0", i, hi + lo); end
      checks++; if (dn !== 0) begin errors++; $display("FAIL short%0d done_pulses got %0d want 0", i, dn); end
      serve(8'd6, 1'b1, T, 0, 1'b0, hi, lo, dn, er, rd, to);
      checks++; if (hi !== 6 * T) begin errors++; $display("FAIL after_short%0d high_cycles got %0d want %0d", i, hi, 6 * T); end
      checks++; if (dn !== 1 || er !== 0) begin errors++; $display("FAIL after_short%0d done/err got %0d/%0d want 1/0", i, dn, er); end
    end
  endtask

  task automatic test_snapshot_hold();
    int hi, lo, dn, er, rd;
    bit to;
    serve(8'd10, 1'b1, T, 0, 1'b1, hi, lo, dn, er, rd, to);
    checks++; if (to) begin errors++; $display("FAIL snapshot timeout busy got %b want 0", bus.busy); end
    checks++; if (hi !== 10 * T) begin errors++; $display("FAIL snapshot high_cycles got %0d want %0d", hi, 10 * T); end
    checks++; if (lo !== LOWH) begin errors++; $display("FAIL snapshot low_cycles got %0d want %0d", lo, LOWH); end
    checks++; if (rd / T !== 10) begin errors++; $display("FAIL snapshot reader got %0d want 10", rd / T); end
  endtask

  task automatic test_reset_mid();
    int seen, hi, lo, dn, er, rd;
    bit to;
    bus.value_in = 8'd8; bus.qtr_ctrl_in = 1'b1;
    @(negedge clk);
    host_mode = 1;
    repeat (T) @(negedge clk);
    host_mode = 0;
    seen = 0;
    for (int n = 0; n < 8 * T && seen < 2 * T; n++) begin
      @(negedge clk);
      if (bus.qtr_out_en && bus.qtr_out_sig) seen++;
    end
    checks++; if (seen < 2 * T) begin errors++; $display("FAIL reset_mid_hold high_cycles got %0d want %0d", seen, 2 * T); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.qtr_out_en !== 1'b0) begin errors++; $display("FAIL reset_mid_out_en got %b want 0", bus.qtr_out_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", bus.busy); end
    host_mode = 2;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    host_mode = 0;
    repeat (3) @(negedge clk);
    serve(8'd4, 1'b1, T, 0, 1'b0, hi, lo, dn, er, rd, to);
    checks++; if (to) begin errors++; $display("FAIL reset_mid_next timeout busy got %b want 0", bus.busy); end
    checks++; if (hi !== 4 * T) begin errors++; $display("FAIL reset_mid_next high_cycles got %0d want %0d", hi, 4 * T); end
    checks++; if (lo !== LOWH || dn !== 1) begin errors++; $display("FAIL reset_mid_next low/done got %0d/%0d want %0d/1", lo, dn, LOWH); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] val;
    logic       ctrl;
    int hi, lo, dn, er, rd, exp_v, len, diff;
    bit to;
    for (int i = 0; i < 6; i++) begin
      val   = 8'($urandom_range(0, 15));
      ctrl  = (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      len   = T + int'($urandom_range(0, 2));
      exp_v = ctrl ? int'(val) : DARK;
      serve(val, ctrl, len, 0, 1'b0, hi, lo, dn, er, rd, to);
      diff = rd / T - exp_v;
      checks++; if (to) begin errors++; $display("FAIL b2b%0d timeout busy got %b want 0", i, bus.busy); end
      checks++; if (hi !== exp_v * T) begin errors++; $display("FAIL b2b%0d high_cycles got %0d want %0d", i, hi, exp_v * T); end
      checks++; if (lo !== LOWH || dn !== 1 || er !== 0) begin errors++; $display("FAIL b2b%0d low/done/err got %0d/%0d/%0d want %0d/1/0", i, lo, dn, er, LOWH); end
      checks++; if (diff > 1 || diff < -1) begin errors++; $display("FAIL b2b%0d reader got %0d want %0d +-1", i, rd / T, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_values();
    test_short_pulse();
    test_snapshot_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
